// File: rtl/text_buffer_writer.sv
// Purpose: ingress text buffer; edits 7-bit ASCII into a line and commits it for the glyph streamer.
// Latency: writes/edits take effect on the transfer edge; read port is registered, 1 cycle.
// Backpressure: o_din_ready drops while a line is committed (DONE) or while i_clear is asserted.
//
// Ports:
//   i_clk, i_reset        single clock, synchronous active-high reset
//   i_din/_valid, o_din_ready   character ingress (transfer = valid & ready)
//   i_clear               empty the buffer and leave DONE
//   i_rd_addr, o_rd_data  streamer read port, FILL_CHAR past the current length
//   o_length, o_done      characters held, line committed flag
module text_buffer_writer #(
  parameter int              WORD_COUNT = 32,
  parameter int              ADDR_W     = $clog2(WORD_COUNT),
  parameter logic [6:0]      FILL_CHAR  = 7'h20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [6:0]        i_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [6:0]        o_rd_data,
  output logic [ADDR_W:0]   o_length,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(WORD_COUNT);
  localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W+1)'(1);

  localparam logic [6:0] C_BS  = 7'h08;
  localparam logic [6:0] C_CR  = 7'h0D;
  localparam logic [6:0] C_ESC = 7'h1B;
  localparam logic [6:0] C_DEL = 7'h7F;

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [6:0]        r_rd_data;
  logic [6:0]        r_mem [WORD_COUNT];

  state_t            w_state_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic              w_wr_en;
  logic              w_xfer;
  logic              w_din_ready;
  logic [6:0]        w_rd_nxt;

  // Ready depends only on state and clear so the upstream sees no path from din_valid.
  assign w_din_ready = (r_state != S_DONE) & ~i_clear;
  assign w_xfer      = i_din_valid & w_din_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_EMPTY;
      r_len     <= '0;
      r_rd_data <= FILL_CHAR;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_rd_data <= w_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wr_en     = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_EMPTY;
      w_len_nxt   = '0;
    end else if (w_xfer) begin
      if (i_din >= 7'h20 && i_din != C_DEL) begin
        // Printable: append; filling the last slot commits the line.
        w_wr_en     = 1'b1;
        w_len_nxt   = r_len + LP_ONE;
        w_state_nxt = (w_len_nxt == LP_FULL) ? S_DONE : S_FILL;
      end else if (i_din == C_BS || i_din == C_DEL) begin
        if (r_len != '0) begin
          w_len_nxt   = r_len - LP_ONE;
          w_state_nxt = (w_len_nxt == '0) ? S_EMPTY : S_FILL;
        end
      end else if (i_din == C_CR) begin
        // Empty lines are never committed.
        if (r_len != '0) begin
          w_state_nxt = S_DONE;
        end
      end else if (i_din == C_ESC) begin
        w_len_nxt   = '0;
        w_state_nxt = S_EMPTY;
      end
    end
  end

  // Storage is not reset; r_len masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_reset) begin
      r_mem[r_len[ADDR_W-1:0]] <= i_din;
    end
  end

  // Uses pre-edge length and contents: read-before-write on a same-address write.
  assign w_rd_nxt = ({1'b0, i_rd_addr} < r_len) ? r_mem[i_rd_addr] : FILL_CHAR;

  assign o_din_ready = w_din_ready;
  assign o_rd_data   = r_rd_data;
  assign o_length    = r_len;
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [6:0] i_din;
  logic       i_din_valid;
  logic       o_din_ready;
  logic       i_clear;
  logic [4:0] i_rd_addr;
  logic [6:0] o_rd_data;
  logic [5:0] o_length;
  logic       o_done;

  text_buffer_writer #(.WORD_COUNT(32), .ADDR_W(5), .FILL_CHAR(7'h20)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .o_din_ready (o_din_ready),
    .i_clear     (i_clear),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_length    (o_length),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of the buffer
  int         m_len  = 0;
  bit         m_done = 1'b0;
  logic [6:0] m_mem [32];
  logic [6:0] sb_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [6:0] c);
    if (c >= 7'h20 && c != 7'h7F) begin
      m_mem[m_len] = c;
      m_len++;
      if (m_len == 32) m_done = 1'b1;
    end else if (c == 7'h08 || c == 7'h7F) begin
      if (m_len > 0) m_len--;
    end else if (c == 7'h0D) begin
      if (m_len > 0) m_done = 1'b1;
    end else if (c == 7'h1B) begin
      m_len = 0;
    end
  endtask

  // One cycle: drive inputs, check ready, optionally issue a read, update model, compare.
  task automatic step(input bit v, input logic [6:0] c, input bit clr,
                      input bit rd, input logic [4:0] a);
    bit         exp_ready;
    logic [6:0] exp_rd;
    i_din       = c;
    i_din_valid = v;
    i_clear     = clr;
    i_rd_addr   = a;
    #1;
    exp_ready = !m_done && !clr;
    chk("din_ready", int'(o_din_ready), int'(exp_ready));
    if (rd) begin
      exp_rd = (int'(a) < m_len) ? m_mem[a] : 7'h20;
      sb_q.push_back(exp_rd);
    end
    @(posedge i_clk);
    if (clr) begin
      m_len  = 0;
      m_done = 1'b0;
    end else if (v && exp_ready) begin
      model_apply(c);
    end
    #1;
    i_din_valid = 1'b0;
    i_clear     = 1'b0;
    if (rd) begin
      if (sb_q.size() == 0) begin
        chk("rd_queue_empty", 1, 0);
      end else begin
        chk("rd_data", int'(o_rd_data), int'(sb_q.pop_front()));
      end
    end
    chk("length", int'(o_length), m_len);
    chk("done", int'(o_done), int'(m_done));
  endtask

  task automatic put(input logic [6:0] c);
    step(1'b1, c, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 7'h00, 1'b0, 1'b1, a);
  endtask

  task automatic do_clear();
    step(1'b0, 7'h00, 1'b1, 1'b0, 5'd0);
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(7'(s[i]));
  endtask

  task automatic do_reset(input bit v, input logic [6:0] c);
    i_reset     = 1'b1;
    i_din       = c;
    i_din_valid = v;
    i_clear     = 1'b0;
    i_rd_addr   = 5'd0;
    @(posedge i_clk);
    #1;
    i_reset     = 1'b0;
    i_din_valid = 1'b0;
    m_len  = 0;
    m_done = 1'b0;
    chk("rst_length", int'(o_length), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rd_data", int'(o_rd_data), 7'h20);
    #1;
    chk("rst_din_ready", int'(o_din_ready), 1);
  endtask

  initial begin
    i_reset = 1'b1; i_din = '0; i_din_valid = 1'b0; i_clear = 1'b0; i_rd_addr = '0;
    @(posedge i_clk);
    #1;
    do_reset(1'b0, 7'h00);

    // 1: "HI" + CR
    put_str("HI");
    put(7'h0D);
    chk("t1_length", int'(o_length), 2);
    chk("t1_done", int'(o_done), 1);
    chk("t1_ready", int'(o_din_ready), 0);
    rd(5'd0);
    chk("t1_rd0", int'(o_rd_data), 7'h48);
    rd(5'd1);
    chk("t1_rd1", int'(o_rd_data), 7'h49);
    rd(5'd2);
    chk("t1_rd2", int'(o_rd_data), 7'h20);
    do_clear();

    // 2: "ABC" BS "D" CR
    put_str("ABC");
    put(7'h08);
    put_str("D");
    put(7'h0D);
    rd(5'd0);
    chk("t2_rd0", int'(o_rd_data), 7'h41);
    rd(5'd1);
    chk("t2_rd1", int'(o_rd_data), 7'h42);
    rd(5'd2);
    chk("t2_rd2", int'(o_rd_data), 7'h44);
    chk("t2_length", int'(o_length), 3);
    do_clear();
    put(7'h08);
    chk("t2_bs_empty_len", int'(o_length), 0);
    chk("t2_bs_empty_done", int'(o_done), 0);

    // 3: 32 x 'Z' fills and commits
    for (int i = 0; i < 32; i++) begin
      put(7'h5A);
      if (i == 30) chk("t3_done_before_full", int'(o_done), 0);
    end
    chk("t3_done_full", int'(o_done), 1);
    chk("t3_length_full", int'(o_length), 32);
    for (int i = 0; i < 3; i++) step(1'b1, 7'h5A, 1'b0, 1'b0, 5'd0);
    chk("t3_held_length", int'(o_length), 32);
    rd(5'd31);
    do_clear();
    chk("t3_clr_length", int'(o_length), 0);
    chk("t3_clr_done", int'(o_done), 0);

    // 4: ESC discards, CR on empty ignored
    put_str("XY");
    put(7'h1B);
    chk("t4_esc_length", int'(o_length), 0);
    for (int i = 0; i < 3; i++) begin
      rd(5'(i));
      chk("t4_fill", int'(o_rd_data), 7'h20);
    end
    put(7'h0D);
    chk("t4_cr_empty_done", int'(o_done), 0);

    // 5: clear beats a simultaneous transfer; control codes discarded
    step(1'b1, 7'h41, 1'b1, 1'b0, 5'd0);
    chk("t5_clr_win_len", int'(o_length), 0);
    put(7'h41);
    chk("t5_len1", int'(o_length), 1);
    put(7'h01);
    chk("t5_ctrl_len", int'(o_length), 1);
    put(7'h7F);
    chk("t5_del_len", int'(o_length), 0);

    // 6: reset mid-line (with a transfer in the reset cycle), then read-before-write
    put_str("ABCDE");
    chk("t6_len5", int'(o_length), 5);
    do_reset(1'b1, 7'h4B);
    step(1'b1, 7'h51, 1'b0, 1'b1, 5'd0);
    chk("t6_rbw", int'(o_rd_data), 7'h20);
    rd(5'd0);
    chk("t6_rd_after", int'(o_rd_data), 7'h51);
    rd(5'd1);
    chk("t6_rd_past_len", int'(o_rd_data), 7'h20);

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
